// File: rtl/dct_idct_requant_pkg.sv
// Shared defaults, block geometry and read FSM encoding for the DCT->IDCT requantizing buffer.
package dct_idct_requant_pkg;

  localparam int unsigned DEF_BIT_WIDTH = 31;
  localparam int unsigned DEF_SHIFT     = 20;
  localparam int unsigned DEF_OUT_BITS  = 12;
  localparam int unsigned BLOCK_SIZE    = 64;
  localparam int unsigned ADDR_W        = $clog2(BLOCK_SIZE);

  typedef enum logic [1:0] {
    RD_IDLE   = 2'd0,
    RD_ARM    = 2'd1,
    RD_STREAM = 2'd2
  } rd_state_e;

endpackage

// File: rtl/dct_idct_requant_requant_sat.sv
// Combinational requantizer: optional round-half-up, arithmetic shift, saturate to OUT_BITS.
// Rounding is enabled by defining REQUANT_ROUND_EN; otherwise the shift truncates.
module requant_sat
  import dct_idct_requant_pkg::*;
#(
  parameter int unsigned BitWidth = DEF_BIT_WIDTH,
  parameter int unsigned SHIFT    = DEF_SHIFT,
  parameter int unsigned OUT_BITS = DEF_OUT_BITS
) (
  input  logic [BitWidth:0]   din,
  output logic [OUT_BITS-1:0] q_c
);

  localparam int unsigned TW = BitWidth + 2;
  localparam logic signed [TW-1:0] SAT_MAX = TW'((1 << (OUT_BITS - 1)) - 1);
  localparam logic signed [TW-1:0] SAT_MIN = ~SAT_MAX;
`ifdef REQUANT_ROUND_EN
  localparam logic signed [TW-1:0] RND = TW'(1) << (SHIFT - 1);
`else
  localparam logic signed [TW-1:0] RND = '0;
`endif

  logic signed [TW-1:0] t;
  logic signed [TW-1:0] s;

  // One extra guard bit keeps the rounding add from wrapping near full scale.
  always_comb begin
    t = $signed({din[BitWidth], din}) + RND;
    s = t >>> SHIFT;
    if (s > SAT_MAX) begin
      q_c = SAT_MAX[OUT_BITS-1:0];
    end else if (s < SAT_MIN) begin
      q_c = SAT_MIN[OUT_BITS-1:0];
    end else begin
      q_c = s[OUT_BITS-1:0];
    end
  end

endmodule

// File: rtl/dct_idct_requant.sv
// Ping-pong requantizing buffer between a DCT producer and an IDCT consumer.
// Build option: REQUANT_ROUND_EN selects round-half-up requantization (default truncation).
module dct_idct_requant
  import dct_idct_requant_pkg::*;
#(
  parameter int unsigned BitWidth = DEF_BIT_WIDTH,
  parameter int unsigned SHIFT    = DEF_SHIFT,
  parameter int unsigned OUT_BITS = DEF_OUT_BITS
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                din_valid,
  input  logic [BitWidth:0]   din,
  input  logic                reading_in,
  output logic                start_out,
  output logic [BitWidth:0]   dout,
  output logic                overflow,
  output logic [15:0]         block_cnt
);

  localparam int unsigned AW = ADDR_W;
  localparam int unsigned DW = BitWidth + 1;
  localparam logic [AW-1:0] LAST = AW'(BLOCK_SIZE - 1);

  logic [OUT_BITS-1:0] q_c;
  logic [OUT_BITS-1:0] mem [2][BLOCK_SIZE];

  logic            wr_bank;
  logic [AW-1:0]   wr_addr;
  logic [1:0]      full;
  logic            wr_en_c;
  logic            wr_last_c;

  rd_state_e       state;
  rd_state_e       state_n;
  logic            rd_bank;
  logic            rd_bank_n;
  logic [AW-1:0]   rd_addr;
  logic [AW-1:0]   rd_addr_n;
  logic            consume_c;
  logic            rd_last_c;
  logic [1:0]      free_c;
  logic            load_c;
  logic            load_bank_c;
  logic [AW-1:0]   load_addr_c;
  logic [OUT_BITS-1:0] rd_word_c;

  requant_sat #(
    .BitWidth (BitWidth),
    .SHIFT    (SHIFT),
    .OUT_BITS (OUT_BITS)
  ) u_requant_sat (
    .din (din),
    .q_c (q_c)
  );

  // A bank being freed this cycle may already accept its first new word.
  always_comb begin
    consume_c = (state != RD_IDLE) && reading_in;
    rd_last_c = consume_c && (rd_addr == LAST);
    free_c    = rd_last_c ? {rd_bank, ~rd_bank} : 2'b00;
    wr_en_c   = din_valid && !(full[wr_bank] && !free_c[wr_bank]);
    wr_last_c = wr_en_c && (wr_addr == LAST);
  end

  always_ff @(posedge clk) begin
    if (wr_en_c) begin
      mem[wr_bank][wr_addr] <= q_c;
    end
  end

  // Write side: fill, discard partial blocks on a gap, drop and flag when full.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_bank  <= 1'b0;
      wr_addr  <= '0;
      full     <= 2'b00;
      overflow <= 1'b0;
    end else begin
      full <= (full & ~free_c) | (wr_last_c ? {wr_bank, ~wr_bank} : 2'b00);
      if (wr_en_c) begin
        wr_addr <= wr_addr + AW'(1);
        if (wr_last_c) begin
          wr_bank <= ~wr_bank;
        end
      end else if (!din_valid) begin
        wr_addr <= '0;
      end
      if (din_valid && !wr_en_c) begin
        overflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RD_IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      RD_IDLE: begin
        if (full[rd_bank]) begin
          state_n = RD_ARM;
        end
      end
      RD_ARM, RD_STREAM: begin
        if (rd_last_c) begin
          state_n = full[~rd_bank] ? RD_ARM : RD_IDLE;
        end else if (consume_c) begin
          state_n = RD_STREAM;
        end
      end
      default: state_n = RD_IDLE;
    endcase
  end

  // Read side: pick the next address and which word to preload into dout.
  always_comb begin
    rd_bank_n   = rd_bank;
    rd_addr_n   = rd_addr;
    load_c      = 1'b0;
    load_bank_c = rd_bank;
    load_addr_c = '0;
    case (state)
      RD_IDLE: begin
        load_c = full[rd_bank];
      end
      RD_ARM, RD_STREAM: begin
        if (rd_last_c) begin
          rd_bank_n   = ~rd_bank;
          rd_addr_n   = '0;
          load_c      = full[~rd_bank];
          load_bank_c = ~rd_bank;
        end else if (consume_c) begin
          rd_addr_n   = rd_addr + AW'(1);
          load_c      = 1'b1;
          load_addr_c = rd_addr + AW'(1);
        end
      end
      default: begin
        rd_addr_n = '0;
      end
    endcase
    rd_word_c = mem[load_bank_c][load_addr_c];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_bank   <= 1'b0;
      rd_addr   <= '0;
      start_out <= 1'b0;
      dout      <= '0;
      block_cnt <= '0;
    end else begin
      rd_bank   <= rd_bank_n;
      rd_addr   <= rd_addr_n;
      start_out <= (state_n != RD_IDLE);
      if (load_c) begin
        dout <= DW'($signed(rd_word_c));
      end
      if (rd_last_c) begin
        block_cnt <= block_cnt + 16'd1;
      end
    end
  end

endmodule

// File: doc/dct_idct_requant.md
DCT_IDCT_REQUANT -- requirements
Module: dct_idct_requant

Interface
REQ-001 Parameter BitWidth, default 31; data words are BitWidth+1 bits wide.
REQ-002 Parameter SHIFT, default 20; arithmetic right-shift applied to each DCT coefficient.
REQ-003 Parameter OUT_BITS, default 12; signed width of the requantized coefficient before sign extension.
REQ-004 clk  input  1  the single clock; all state updates on the rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 din_valid  input  1  DCT done; a coefficient is present on din every cycle it is high.
REQ-007 din  input  BitWidth+1  signed DCT coefficient.
REQ-008 reading_in  input  1  IDCT reading; the IDCT consumes dout in every cycle this is high.
REQ-009 start_out  output  1  drives the IDCT start input; high while a full block is available.
REQ-010 dout  output  BitWidth+1  requantized coefficient, sign-extended.
REQ-011 overflow  output  1  sticky; set when a coefficient is dropped because both banks are full.
REQ-012 block_cnt  output  16  count of blocks fully delivered to the IDCT; wraps at 65535 to 0.

Function
REQ-013 Requant: t = din (+ 2^(SHIFT-1) when rounding is enabled), computed at BitWidth+2 bits; q = t >>> SHIFT; saturate q to [-2^(OUT_BITS-1), 2^(OUT_BITS-1)-1]; dout = sign-extend(q).
REQ-014 Storage is two 64-entry ping-pong banks of OUT_BITS-wide words.
REQ-015 Write side: each din_valid cycle writes into the current write bank at wr_addr, then wr_addr increments; the write of address 63 marks the bank FULL, resets wr_addr to 0 and toggles the write bank.
REQ-016 din_valid low while wr_addr != 0: the partial block is discarded and wr_addr returns to 0.
REQ-017 din_valid high while the write bank is FULL: the sample is dropped and overflow is set.
REQ-018 Read FSM states: IDLE, ARM, STREAM.
REQ-019 IDLE -> ARM on the cycle after a bank becomes FULL; ARM asserts start_out and presents word 0 of the oldest FULL bank on dout.
REQ-020 ARM -> STREAM on the first cycle reading_in=1; in ARM and STREAM, rd_addr advances once per cycle with reading_in=1, and dout shows the word at rd_addr, registered.
REQ-021 On the consume of word 63: the bank is freed, block_cnt increments, and the FSM goes to ARM if the other bank is FULL, otherwise to IDLE with start_out=0.
REQ-022 reading_in low during STREAM: rd_addr and dout hold.
REQ-023 When a bank frees and the same bank's 64th write occur in the same cycle, both succeed; free takes effect before full.
REQ-024 Latency from the 64th write to start_out=1 is 1 cycle when IDLE.

Reset
REQ-025 reset=1 for one edge sets start_out=0, dout=0, overflow=0, block_cnt=0, wr_addr=rd_addr=0, both banks not FULL, bank select 0, FSM IDLE.
REQ-026 Reset mid-block discards all buffered data; bank contents need not be cleared.

Configuration
REQ-027 Macro REQUANT_ROUND_EN: when defined, add 2^(SHIFT-1) before the shift (round half up); when undefined, pure truncation, bit-identical to dout = din[BitWidth:SHIFT] sign-extended, saturated.

Structure
REQ-028 A shared package holds the BitWidth/SHIFT/OUT_BITS defaults, the block size constant 64, and the read FSM state enum.
REQ-029 Sub-module requant_sat (combinational shift/round/saturate) is instantiated once on the write path.

Verification
REQ-030 64 writes of din=0x0010_0000, reading_in=1 -> start_out rises 1 cycle after the last write; 64 words of dout=0x0000_0001; block_cnt=1.
REQ-031 din=0x0008_0000 -> dout=0x0000_0001 with REQUANT_ROUND_EN, 0x0000_0000 without; din=0xFFF0_0000 -> dout=0xFFFF_FFFF.
REQ-032 din=0x7FF8_0000 with rounding -> dout=0x0000_07FF (saturated); din=0x8000_0000 -> dout=0xFFFF_F800.
REQ-033 reading_in=0 while 129 consecutive valid words arrive -> banks 0 and 1 FULL, word 129 dropped, overflow=1, sticky until reset.
REQ-034 din_valid drops after 40 words, then 64 words arrive -> exactly one block is delivered, containing the later 64 words.
REQ-035 Assert reset at read word 30 -> next cycle start_out=0, block_cnt=0; the following full block streams normally.
